// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

  // Loader sequencing states.
  typedef enum logic [2:0] {
    LEN_LO = 3'd0,
    LEN_HI = 3'd1,
    DATA   = 3'd2,
    CSUM   = 3'd3,
    DONE   = 3'd4,
    ERROR  = 3'd5
  } state_e;

  // Stream bytes that make up one 32-bit instruction word.
  localparam int BYTES_PER_WORD = 4;

  // Length header bytes preceding the data (little-endian word count).
  localparam int HDR_BYTES = 2;

endpackage

// File: rtl/byte_word_packer.sv
// 8-to-32 little-endian packer: the first byte of each word lands in [7:0].
// word_valid_o pulses for one cycle, the cycle after the 4th byte of a word.
module byte_word_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        n_rst,
  input  logic        clr_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic        last_byte_o,
  output logic [31:0] word_o,
  output logic        word_valid_o
);

  localparam int CNT_W = $clog2(BYTES_PER_WORD);

  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      buf_q;
  logic [31:0]      buf_d;
  logic [31:0]      word_q;
  logic             valid_q;

  // New bytes enter at the top so that after four shifts byte 0 sits at [7:0].
  assign buf_d       = {byte_i, buf_q[31:8]};
  assign last_byte_o = byte_valid_i && (cnt_q == CNT_W'(BYTES_PER_WORD - 1));

  // Shift register, byte counter and the registered word/strobe pair.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q   <= '0;
      buf_q   <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= last_byte_o;
      if (clr_i) begin
        cnt_q <= '0;
        buf_q <= '0;
      end else if (byte_valid_i) begin
        cnt_q <= cnt_q + CNT_W'(1);
        buf_q <= buf_d;
        if (last_byte_o) begin
          word_q <= buf_d;
        end
      end
    end
  end

  assign word_o       = word_q;
  assign word_valid_o = valid_q;

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: parses a length-prefixed byte stream, writes
// the packed words from address 0 upward, verifies an XOR checksum and
// releases the core from reset only once the program is loaded and good.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int NUM_INSTR = 32,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              load_req,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_n_rst,
  output logic              done,
  output logic              error
);

  localparam int IDX_W = $clog2(NUM_INSTR + 1);
  localparam int LEN_W = HDR_BYTES * 8;

  state_e           state_q;
  logic [7:0]       len_lo_q;
  logic [IDX_W-1:0] n_q;
  logic [IDX_W-1:0] word_idx_q;
  logic [7:0]       csum_q;
  logic             core_n_rst_q;
  logic             done_q;
  logic             error_q;

  logic             xfer;
  logic [LEN_W-1:0] len_full;
  logic             restart;
  logic             pk_valid;
  logic             pk_last;
  logic [31:0]      pk_word;
  logic             pk_word_valid;

  assign in_ready = (state_q != DONE) && (state_q != ERROR);
  assign xfer     = in_valid && in_ready;
  assign len_full = {in_data, len_lo_q};
  assign restart  = load_req && ((state_q == DONE) || (state_q == ERROR));
  assign pk_valid = xfer && (state_q == DATA);

  byte_word_packer u_packer (
    .clk          (clk),
    .n_rst        (n_rst),
    .clr_i        (restart),
    .byte_valid_i (pk_valid),
    .byte_i       (in_data),
    .last_byte_o  (pk_last),
    .word_o       (pk_word),
    .word_valid_o (pk_word_valid)
  );

  // Sequencing FSM with the word index, running checksum and status flags.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= LEN_LO;
      len_lo_q     <= '0;
      n_q          <= '0;
      word_idx_q   <= '0;
      csum_q       <= '0;
      core_n_rst_q <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      // The index advances at the end of the write cycle, so the address
      // seen with the strobe is always that of the word being written.
      if (pk_word_valid) begin
        word_idx_q <= word_idx_q + IDX_W'(1);
      end

      unique case (state_q)
        LEN_LO: begin
          if (xfer) begin
            len_lo_q <= in_data;
            state_q  <= LEN_HI;
          end
        end

        LEN_HI: begin
          if (xfer) begin
            n_q <= len_full[IDX_W-1:0];
            if (len_full > LEN_W'(NUM_INSTR)) begin
              state_q <= ERROR;
              error_q <= 1'b1;
            end else if (len_full == '0) begin
              state_q <= CSUM;
            end else begin
              state_q <= DATA;
            end
          end
        end

        DATA: begin
          if (xfer) begin
            csum_q <= csum_q ^ in_data;
            // Previous word's increment has long since landed, so word_idx_q
            // is the index of the word this byte completes.
            if (pk_last && (word_idx_q == n_q - IDX_W'(1))) begin
              state_q <= CSUM;
            end
          end
        end

        CSUM: begin
          if (xfer) begin
            if (in_data == csum_q) begin
              state_q      <= DONE;
              done_q       <= 1'b1;
              core_n_rst_q <= 1'b1;
            end else begin
              state_q <= ERROR;
              error_q <= 1'b1;
            end
          end
        end

        DONE, ERROR: begin
          if (load_req) begin
            state_q      <= LEN_LO;
            len_lo_q     <= '0;
            n_q          <= '0;
            word_idx_q   <= '0;
            csum_q       <= '0;
            core_n_rst_q <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
          end
        end

        default: begin
          state_q <= LEN_LO;
        end
      endcase
    end
  end

  assign imem_we    = pk_word_valid;
  assign imem_wdata = pk_word;
  assign imem_addr  = ADDR_W'({word_idx_q, 2'b00});
  assign core_n_rst = core_n_rst_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule
